// File: rtl/ex_stage.sv
// Execute stage: latches the decode bundle, runs the ALU, drives the data SRAM and forwarding paths,
// and owns HI/LO with a radix-2 restoring divider that holds EX via stallreq.
module ex_stage #(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [5:0]   stall,
  output logic         stallreq,
  input  logic [158:0] id_to_ex_bus,
  output logic [75:0]  ex_to_mem_bus,
  output logic [37:0]  ex_to_id_bus,
  output logic         data_sram_en,
  output logic [3:0]   data_sram_wen,
  output logic [31:0]  data_sram_addr,
  output logic [31:0]  data_sram_wdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [4:0] CNT_LAST = 5'(DIV_CYCLES - 1);

  logic [158:0] bus_r;
  logic         bus_load;

  always_ff @(posedge clk) begin
    if (rst)                     bus_r <= '0;
    else if (stall[2] && !stall[3]) bus_r <= '0;
    else if (!stall[2])          bus_r <= id_to_ex_bus;
  end

  assign bus_load = (stall[2] && !stall[3]) || !stall[2];

  logic [31:0] pc, inst, reg1, reg2;
  logic [11:0] alu_op;
  logic [2:0]  src1;
  logic [3:0]  src2, ram_wen;
  logic        ram_en, rf_we, sel_rf_res;
  logic [4:0]  rf_waddr;

  assign pc         = bus_r[158:127];
  assign inst       = bus_r[126:95];
  assign alu_op     = bus_r[94:83];
  assign src1       = bus_r[82:80];
  assign src2       = bus_r[79:76];
  assign ram_en     = bus_r[75];
  assign ram_wen    = bus_r[74:71];
  assign rf_we      = bus_r[70];
  assign rf_waddr   = bus_r[69:65];
  assign sel_rf_res = bus_r[64];
  assign reg1       = bus_r[63:32];
  assign reg2       = bus_r[31:0];

  logic [31:0] a, b, alu_res;

  always_comb begin
    a = '0;
    if (src1[0])      a = reg1;
    else if (src1[1]) a = pc;
    else if (src1[2]) a = {27'b0, inst[10:6]};
    b = '0;
    if (src2[0])      b = reg2;
    else if (src2[1]) b = {{16{inst[15]}}, inst[15:0]};
    else if (src2[2]) b = 32'd8;
    else if (src2[3]) b = {16'b0, inst[15:0]};
  end

  always_comb begin
    alu_res = '0;
    if (alu_op[11]) alu_res = alu_res | (a + b);
    if (alu_op[10]) alu_res = alu_res | (a - b);
    if (alu_op[9])  alu_res = alu_res | {31'b0, $signed(a) < $signed(b)};
    if (alu_op[8])  alu_res = alu_res | {31'b0, a < b};
    if (alu_op[7])  alu_res = alu_res | (a & b);
    if (alu_op[6])  alu_res = alu_res | ~(a | b);
    if (alu_op[5])  alu_res = alu_res | (a | b);
    if (alu_op[4])  alu_res = alu_res | (a ^ b);
    if (alu_op[3])  alu_res = alu_res | (b << a[4:0]);
    if (alu_op[2])  alu_res = alu_res | (b >> a[4:0]);
    if (alu_op[1])  alu_res = alu_res | $unsigned($signed(b) >>> a[4:0]);
    if (alu_op[0])  alu_res = alu_res | {b[15:0], 16'b0};
  end

  logic       is_special, is_mfhi, is_mflo, is_mthi, is_mtlo, is_div, div_signed;
  logic [5:0] func;

  assign func       = inst[5:0];
  assign is_special = (inst[31:26] == 6'b0);
  assign is_mfhi    = is_special && (func == 6'h10);
  assign is_mthi    = is_special && (func == 6'h11);
  assign is_mflo    = is_special && (func == 6'h12);
  assign is_mtlo    = is_special && (func == 6'h13);
  assign is_div     = is_special && ((func == 6'h1A) || (func == 6'h1B));
  assign div_signed = (func == 6'h1A);

  logic [31:0] hi, lo, ex_result;
  logic        rf_we_eff, fwd_we;
  logic [3:0]  wen_eff;

  assign ex_result = is_mfhi ? hi : (is_mflo ? lo : alu_res);
  assign rf_we_eff = rf_we && !is_div;
  assign wen_eff   = ram_en ? ram_wen : 4'b0;
  assign fwd_we    = rf_we_eff && !sel_rf_res;

  assign ex_to_mem_bus   = {pc, ram_en, wen_eff, sel_rf_res, rf_we_eff, rf_waddr, ex_result};
  assign ex_to_id_bus    = {fwd_we, rf_waddr, ex_result};
  assign data_sram_en    = ram_en;
  assign data_sram_wen   = wen_eff;
  assign data_sram_addr  = ex_result;
  assign data_sram_wdata = reg2;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [31:0] rem, quo, dsor, abs_rs, abs_rt, rem_next;
  logic [32:0] shifted, diff;
  logic        neg_q, neg_r, dsor_zero, done_flag, step_ge;

  assign abs_rs = (div_signed && reg1[31]) ? (32'd0 - reg1) : reg1;
  assign abs_rt = (div_signed && reg2[31]) ? (32'd0 - reg2) : reg2;

  // Invariant rem < dsor keeps the trial difference inside 32 bits.
  assign shifted  = {rem, quo[31]};
  assign diff     = shifted - {1'b0, dsor};
  assign step_ge  = (shifted >= {1'b0, dsor});
  assign rem_next = step_ge ? diff[31:0] : shifted[31:0];

  assign stallreq = (state == S_BUSY) || ((state == S_IDLE) && is_div && !done_flag);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rem       <= '0;
      quo       <= '0;
      dsor      <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      dsor_zero <= 1'b0;
      done_flag <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (is_div && !done_flag) begin
            state     <= S_BUSY;
            cnt       <= '0;
            rem       <= '0;
            quo       <= abs_rs;
            dsor      <= abs_rt;
            neg_q     <= div_signed && (reg1[31] ^ reg2[31]);
            neg_r     <= div_signed && reg1[31];
            dsor_zero <= (reg2 == 32'd0);
          end
        end
        S_BUSY: begin
          rem <= rem_next;
          quo <= {quo[30:0], step_ge};
          cnt <= cnt + 5'd1;
          if (cnt == CNT_LAST) state <= S_DONE;
        end
        S_DONE: begin
          hi    <= neg_r ? (32'd0 - rem) : rem;
          lo    <= dsor_zero ? '1 : (neg_q ? (32'd0 - quo) : quo);
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      if (!stall[2] && is_mthi) hi <= reg1;
      if (!stall[2] && is_mtlo) lo <= reg1;
      // A fresh instruction entering EX must be allowed to start its own divide.
      if (bus_load)              done_flag <= 1'b0;
      else if (state == S_DONE)  done_flag <= 1'b1;
    end
  end

  logic sig_unused;
  assign sig_unused = ^{stall[5:4], stall[1:0], inst[25:16], diff[32]};

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: stimulus pushes hand-computed results into a queue,
// a negedge monitor pops one entry each time an instruction leaves EX toward MEM.
module tb_ex_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   stall, stall_ext;
  logic         stallreq;
  logic [158:0] id_to_ex_bus;
  logic [75:0]  ex_to_mem_bus;
  logic [37:0]  ex_to_id_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr, data_sram_wdata;

  ex_stage #(.DIV_CYCLES(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .stallreq(stallreq),
    .id_to_ex_bus(id_to_ex_bus), .ex_to_mem_bus(ex_to_mem_bus), .ex_to_id_bus(ex_to_id_bus),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata)
  );

  always #5 clk = ~clk;

  // Minimal stall controller: a divide holds PC..EX and bubbles MEM.
  assign stall = stallreq ? 6'b001111 : stall_ext;

  typedef struct {
    logic [75:0] mem;
    logic [37:0] fwd;
    logic [68:0] sram;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   ncyc;

  task automatic check(input string name, input logic [75:0] act, input logic [75:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic [158:0] mk(input logic [31:0] pc, input logic [31:0] inst,
                                      input logic [11:0] op, input logic [2:0] s1, input logic [3:0] s2,
                                      input logic ren, input logic [3:0] rwen, input logic we,
                                      input logic [4:0] wa, input logic sel,
                                      input logic [31:0] r1, input logic [31:0] r2);
    return {pc, inst, op, s1, s2, ren, rwen, we, wa, sel, r1, r2};
  endfunction

  task automatic expect_out(input logic [31:0] pc, input logic ren, input logic [3:0] wen,
                            input logic sel, input logic we, input logic [4:0] wa,
                            input logic [31:0] res, input logic fwe, input logic [31:0] wdata);
    exp_t e;
    e.mem  = {pc, ren, wen, sel, we, wa, res};
    e.fwd  = {fwe, wa, res};
    e.sram = {ren, wen, res, wdata};
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [158:0] b);
    id_to_ex_bus = b;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_div(output int n);
    n = 0;
    while (stallreq && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (!rst && ex_to_mem_bus[75:44] != 32'd0 && !stall[3]) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got pc %0h required none", ex_to_mem_bus[75:44]);
      end else begin
        mon_e = exp_q.pop_front();
        check("mem_bus", ex_to_mem_bus, mon_e.mem);
        check("fwd_bus", 76'(ex_to_id_bus), 76'(mon_e.fwd));
        check("sram", 76'({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}), 76'(mon_e.sram));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    stall_ext = 6'b0;
    id_to_ex_bus = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_mem_bus", ex_to_mem_bus, 76'd0);
    check("reset_fwd_bus", 76'(ex_to_id_bus), 76'd0);
    check("reset_sram", 76'({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}), 76'd0);
    check("reset_stallreq", 76'(stallreq), 76'd0);
    rst = 1'b0;

    // ALU paths
    expect_out(32'hBFC00000, 1'b0, 4'h0, 1'b0, 1'b1, 5'd2, 32'd4, 1'b1, 32'd0);
    issue(mk(32'hBFC00000, 32'h2422FFFF, 12'h800, 3'b001, 4'b0010, 1'b0, 4'h0, 1'b1, 5'd2, 1'b0, 32'd5, 32'd0));
    expect_out(32'hBFC00004, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0, 32'h100, 1'b0, 32'hAB);
    issue(mk(32'hBFC00004, 32'hAC230010, 12'h800, 3'b001, 4'b0010, 1'b1, 4'hF, 1'b0, 5'd0, 1'b0, 32'hF0, 32'hAB));
    expect_out(32'hBFC00008, 1'b1, 4'h0, 1'b1, 1'b1, 5'd4, 32'h204, 1'b0, 32'h55);
    issue(mk(32'hBFC00008, 32'h8C240004, 12'h800, 3'b001, 4'b0010, 1'b1, 4'h0, 1'b1, 5'd4, 1'b1, 32'h200, 32'h55));
    expect_out(32'hBFC0000C, 1'b0, 4'h0, 1'b0, 1'b1, 5'd5, 32'd1, 1'b1, 32'd1);
    issue(mk(32'hBFC0000C, 32'h0022282A, 12'h200, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd5, 1'b0, 32'hFFFFFFFF, 32'd1));
    expect_out(32'hBFC00010, 1'b0, 4'h0, 1'b0, 1'b1, 5'd5, 32'd0, 1'b1, 32'd1);
    issue(mk(32'hBFC00010, 32'h0022282B, 12'h100, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd5, 1'b0, 32'hFFFFFFFF, 32'd1));
    expect_out(32'hBFC00014, 1'b0, 4'h0, 1'b0, 1'b1, 5'd6, 32'hF8000000, 1'b1, 32'h80000000);
    issue(mk(32'hBFC00014, 32'h00023103, 12'h002, 3'b100, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd6, 1'b0, 32'd0, 32'h80000000));
    expect_out(32'hBFC00018, 1'b0, 4'h0, 1'b0, 1'b1, 5'd8, 32'hF000FF00, 1'b1, 32'h00FF00FF);
    issue(mk(32'hBFC00018, 32'h00224027, 12'h040, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd8, 1'b0, 32'h0F0F0000, 32'h00FF00FF));
    expect_out(32'hBFC0001C, 1'b0, 4'h0, 1'b0, 1'b1, 5'd7, 32'h12340000, 1'b1, 32'd0);
    issue(mk(32'hBFC0001C, 32'h3C071234, 12'h001, 3'b000, 4'b1000, 1'b0, 4'h0, 1'b1, 5'd7, 1'b0, 32'd0, 32'd0));
    expect_out(32'hBFC00020, 1'b0, 4'h0, 1'b0, 1'b1, 5'd31, 32'hBFC00028, 1'b1, 32'd0);
    issue(mk(32'hBFC00020, 32'h0C000000, 12'h800, 3'b010, 4'b0100, 1'b0, 4'h0, 1'b1, 5'd31, 1'b0, 32'd0, 32'd0));
    expect_out(32'hBFC00024, 1'b0, 4'h0, 1'b0, 1'b1, 5'd9, 32'hFFFFFFFF, 1'b1, 32'd1);
    issue(mk(32'hBFC00024, 32'h00224823, 12'h400, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd9, 1'b0, 32'd0, 32'd1));

    // Bubble insertion, then hold
    stall_ext = 6'b000111;
    issue(mk(32'hBFC00030, 32'h24220001, 12'h800, 3'b001, 4'b0010, 1'b0, 4'h0, 1'b1, 5'd2, 1'b0, 32'd1, 32'd0));
    check("bubble_mem_bus", ex_to_mem_bus, 76'd0);
    check("bubble_fwd_bus", 76'(ex_to_id_bus), 76'd0);
    check("bubble_sram", 76'({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}), 76'd0);
    stall_ext = 6'b0;
    expect_out(32'hBFC00040, 1'b0, 4'h0, 1'b0, 1'b1, 5'd2, 32'd7, 1'b1, 32'd0);
    issue(mk(32'hBFC00040, 32'h24220004, 12'h800, 3'b001, 4'b0010, 1'b0, 4'h0, 1'b1, 5'd2, 1'b0, 32'd3, 32'd0));
    stall_ext = 6'b001111;
    issue(mk(32'hBFC00044, 32'h3C08ABCD, 12'h001, 3'b000, 4'b1000, 1'b0, 4'h0, 1'b1, 5'd8, 1'b0, 32'd0, 32'd0));
    check("hold_pc", 76'(ex_to_mem_bus[75:44]), 76'(32'hBFC00040));
    stall_ext = 6'b0;
    expect_out(32'hBFC00044, 1'b0, 4'h0, 1'b0, 1'b1, 5'd8, 32'hABCD0000, 1'b1, 32'd0);
    issue(mk(32'hBFC00044, 32'h3C08ABCD, 12'h001, 3'b000, 4'b1000, 1'b0, 4'h0, 1'b1, 5'd8, 1'b0, 32'd0, 32'd0));

    // DIVU 100/7
    expect_out(32'hBFC00050, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd7);
    issue(mk(32'hBFC00050, 32'h0022001B, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b1, 5'd0, 1'b0, 32'd100, 32'd7));
    wait_div(ncyc);
    check("divu_stall_cycles", 76'(ncyc), 76'd33);
    expect_out(32'hBFC00054, 1'b0, 4'h0, 1'b0, 1'b1, 5'd3, 32'd14, 1'b1, 32'd0);
    issue(mk(32'hBFC00054, 32'h00001812, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'd0, 32'd0));
    expect_out(32'hBFC00058, 1'b0, 4'h0, 1'b0, 1'b1, 5'd4, 32'd2, 1'b1, 32'd0);
    issue(mk(32'hBFC00058, 32'h00002010, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b1, 5'd4, 1'b0, 32'd0, 32'd0));

    // DIV -7/2
    expect_out(32'hBFC00060, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd2);
    issue(mk(32'hBFC00060, 32'h0022001A, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b1, 5'd0, 1'b0, 32'hFFFFFFF9, 32'd2));
    wait_div(ncyc);
    check("div_stall_cycles", 76'(ncyc), 76'd33);
    expect_out(32'hBFC00064, 1'b0, 4'h0, 1'b0, 1'b1, 5'd3, 32'hFFFFFFFD, 1'b1, 32'd0);
    issue(mk(32'hBFC00064, 32'h00001812, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'd0, 32'd0));
    expect_out(32'hBFC00068, 1'b0, 4'h0, 1'b0, 1'b1, 5'd4, 32'hFFFFFFFF, 1'b1, 32'd0);
    issue(mk(32'hBFC00068, 32'h00002010, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b1, 5'd4, 1'b0, 32'd0, 32'd0));

    // DIV 5/0, externally held through DONE: must not restart
    expect_out(32'hBFC00070, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
    issue(mk(32'hBFC00070, 32'h0022001A, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b1, 5'd0, 1'b0, 32'd5, 32'd0));
    wait_div(ncyc);
    check("div0_stall_cycles", 76'(ncyc), 76'd33);
    stall_ext = 6'b001111;
    issue(mk(32'hBFC00074, 32'h00001812, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'd0, 32'd0));
    check("held_no_restart", 76'(stallreq), 76'd0);
    stall_ext = 6'b0;
    expect_out(32'hBFC00074, 1'b0, 4'h0, 1'b0, 1'b1, 5'd3, 32'hFFFFFFFF, 1'b1, 32'd0);
    issue(mk(32'hBFC00074, 32'h00001812, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'd0, 32'd0));
    expect_out(32'hBFC00078, 1'b0, 4'h0, 1'b0, 1'b1, 5'd4, 32'd5, 1'b1, 32'd0);
    issue(mk(32'hBFC00078, 32'h00002010, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b1, 5'd4, 1'b0, 32'd0, 32'd0));

    // MTHI then MFHI
    expect_out(32'hBFC00080, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
    issue(mk(32'hBFC00080, 32'h00200011, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'hDEADBEEF, 32'd0));
    expect_out(32'hBFC00084, 1'b0, 4'h0, 1'b0, 1'b1, 5'd4, 32'hDEADBEEF, 1'b1, 32'd0);
    issue(mk(32'hBFC00084, 32'h00002010, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b1, 5'd4, 1'b0, 32'd0, 32'd0));

    // Reset in the middle of a divide (cnt=10)
    issue(mk(32'hBFC00090, 32'h0022001B, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'd100, 32'd7));
    id_to_ex_bus = '0;
    repeat (11) begin
      @(posedge clk);
      #1;
    end
    check("busy_before_reset", 76'(stallreq), 76'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_mid_div_stallreq", 76'(stallreq), 76'd0);
    expect_out(32'hBFC00094, 1'b0, 4'h0, 1'b0, 1'b1, 5'd4, 32'd0, 1'b1, 32'd0);
    issue(mk(32'hBFC00094, 32'h00002010, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b1, 5'd4, 1'b0, 32'd0, 32'd0));
    expect_out(32'hBFC00098, 1'b0, 4'h0, 1'b0, 1'b1, 5'd3, 32'd0, 1'b1, 32'd0);
    issue(mk(32'hBFC00098, 32'h00001812, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'd0, 32'd0));

    // DIVU 0xFFFFFFFF/16 after reset
    expect_out(32'hBFC000A0, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd16);
    issue(mk(32'hBFC000A0, 32'h0022001B, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b1, 5'd0, 1'b0, 32'hFFFFFFFF, 32'd16));
    wait_div(ncyc);
    check("divu_after_reset_cycles", 76'(ncyc), 76'd33);
    expect_out(32'hBFC000A4, 1'b0, 4'h0, 1'b0, 1'b1, 5'd3, 32'h0FFFFFFF, 1'b1, 32'd0);
    issue(mk(32'hBFC000A4, 32'h00001812, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'd0, 32'd0));
    expect_out(32'hBFC000A8, 1'b0, 4'h0, 1'b0, 1'b1, 5'd4, 32'd15, 1'b1, 32'd0);
    issue(mk(32'hBFC000A8, 32'h00002010, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b1, 5'd4, 1'b0, 32'd0, 32'd0));

    issue('0);
    issue('0);
    check("scoreboard_drained", 76'(exp_q.size()), 76'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
